// File: rtl/mem_bus_arbiter.sv
// Shares one AXI4 master port between instruction fetch (read-only) and data access
// (read/write) with two-way round-robin arbitration and a REQ/ACK pipeline handshake.
module mem_bus_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          I_REQ,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_ADDR,
  output logic                          I_ACK,
  input  logic                          D_REQ,
  input  logic                          D_WE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] D_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] D_WDATA,
  output logic                          D_ACK,
  output logic [C_M_AXI_DATA_WIDTH-1:0] RDATA,
  output logic                          ERR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic r_last_d;
  logic r_grant_d;
  logic r_aw_done;
  logic r_w_done;
  logic r_err;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;

  logic w_any_req;
  logic w_pick_d;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_ok;
  logic w_w_ok;

  // On a tie the requester not served last wins; r_last_d resets low so D goes first.
  assign w_any_req = I_REQ | D_REQ;
  assign w_pick_d  = D_REQ & (~I_REQ | ~r_last_d);

  assign M_AXI_ARVALID = (r_state == S_AR);
  assign M_AXI_RREADY  = (r_state == S_R);
  assign M_AXI_AWVALID = (r_state == S_AW_W) & ~r_aw_done;
  assign M_AXI_WVALID  = (r_state == S_AW_W) & ~r_w_done;
  assign M_AXI_BREADY  = (r_state == S_B);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_WDATA   = r_wdata;

  assign w_ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign w_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;

  assign I_ACK = (r_state == S_DONE) & ~r_grant_d;
  assign D_ACK = (r_state == S_DONE) & r_grant_d;
  assign RDATA = r_rdata;
  assign ERR   = r_err;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = (w_pick_d && D_WE) ? S_AW_W : S_AR;
      S_AR:   if (w_ar_hs) w_next = S_R;
      S_R:    if (M_AXI_RVALID) w_next = S_DONE;
      S_AW_W: if (w_aw_ok && w_w_ok) w_next = S_B;
      S_B:    if (M_AXI_BVALID) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_last_d  <= 1'b0;
      r_grant_d <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_d <= w_pick_d;
            r_last_d  <= w_pick_d;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (w_pick_d && D_WE) begin
              r_awaddr <= D_ADDR;
              r_wdata  <= D_WDATA;
            end else begin
              r_araddr <= w_pick_d ? D_ADDR : I_ADDR;
            end
          end
        end
        S_R: begin
          if (M_AXI_RVALID) begin
            r_rdata <= M_AXI_RDATA;
            r_err   <= |M_AXI_RRESP;
          end
        end
        // AW and W complete independently; each VALID drops after its own handshake.
        S_AW_W: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_B: begin
          if (M_AXI_BVALID) r_err <= |M_AXI_BRESP;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
